// File: rtl/div_fp64_issue_ctrl.sv
// div_fp64_issue_ctrl: buffers tagged divide requests, issues them one at a time to div_fp64,
// and returns each quotient with its flags through a valid/ready response port.
module div_fp64_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_rm,
  input  logic [63:0]      req_dividend,
  input  logic [63:0]      req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  // divider issue side
  output logic             div_valid_in,
  output logic [2:0]       div_rm,
  output logic [63:0]      div_dividend,
  output logic [63:0]      div_divisor,
  // divider result side
  input  logic             div_valid_out,
  input  logic [63:0]      div_quotient,
  input  logic             div_nv,
  input  logic             div_dz,
  input  logic             div_of,
  input  logic             div_uf,
  input  logic             div_nx,
  // response port
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_quotient,
  output logic [4:0]       resp_flags,
  output logic [TAG_W-1:0] resp_tag,
  // sticky flags and status
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q;
  logic [2:0]       fifo_rm    [DEPTH];
  logic [63:0]      fifo_a     [DEPTH];
  logic [63:0]      fifo_b     [DEPTH];
  logic [TAG_W-1:0] fifo_tag   [DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [PtrW:0]    count_q;
  logic [TAG_W-1:0] tag_q;

  logic             full;
  logic             push;
  logic             issue;
  logic             capture;
  logic [4:0]       div_flags;

  assign full      = (count_q == (PtrW+1)'(DEPTH));
  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready = !reset && !full;
  assign push      = req_valid && req_ready;
  // Never issue while an unconsumed response would be overwritten by the result.
  assign issue     = (state_q == StIdle) && (count_q != '0) && (!resp_valid || resp_ready);
  assign capture   = (state_q == StWait) && div_valid_out;
  assign div_flags = {div_nv, div_dz, div_of, div_uf, div_nx};
  assign busy      = (count_q != '0) || (state_q == StWait) || resp_valid;

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rm[wptr_q]  <= req_rm;
      fifo_a[wptr_q]   <= req_dividend;
      fifo_b[wptr_q]   <= req_divisor;
      fifo_tag[wptr_q] <= req_tag;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (issue) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + (PtrW+1)'(push) - (PtrW+1)'(issue);
    end
  end

  // Issue/wait FSM with registered divider operands, response registers and sticky flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      div_valid_in  <= 1'b0;
      div_rm        <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      tag_q         <= '0;
      resp_valid    <= 1'b0;
      resp_quotient <= '0;
      resp_flags    <= '0;
      resp_tag      <= '0;
      fflags        <= '0;
    end else begin
      div_valid_in <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            div_valid_in <= 1'b1;
            div_rm       <= fifo_rm[rptr_q];
            div_dividend <= fifo_a[rptr_q];
            div_divisor  <= fifo_b[rptr_q];
            tag_q        <= fifo_tag[rptr_q];
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (div_valid_out) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (capture) begin
        resp_valid    <= 1'b1;
        resp_quotient <= div_quotient;
        resp_flags    <= div_flags;
        resp_tag      <= tag_q;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end

      // A clear on the capture edge still keeps the newly returned flags.
      fflags <= (fflags_clr ? 5'b0 : fflags) | (capture ? div_flags : 5'b0);
    end
  end

endmodule
